// File: rtl/spi_txn_sequencer_pkg.sv
// Shared definitions for the SPI transaction sequencer: FSM encoding,
// slave-index field geometry and clock-divider defaults.
package spi_txn_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP,
    ST_DONE
  } state_t;

  // Slave index lives in the top SLV_FIELD_W bits of each address byte.
  localparam int SLV_FIELD_W = 2;
  localparam int DEF_CLK_DIV = 4;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_txn_sequencer_if.sv
// Register-file / SPI-pin bundle of the transaction sequencer.
// The master modport is the sequencer's own view.
interface spi_txn_sequencer_if #(
  parameter int NUM_OF_SLAVES = 3,
  parameter int WIDTH         = 8,
  parameter int MAX_TXNS      = 8
);
  localparam int IDXW = $clog2(MAX_TXNS);

  logic                     start_i;
  logic [IDXW-1:0]          num_txns_i;
  logic [IDXW-1:0]          rd_idx_o;
  logic [WIDTH-1:0]         addr_byte_i;
  logic [WIDTH-1:0]         data_byte_i;
  logic                     rx_we_o;
  logic [IDXW-1:0]          rx_idx_o;
  logic [WIDTH-1:0]         rx_data_o;
  logic                     busy_o;
  logic                     done_o;
  logic                     err_o;
  logic                     sclk;
  logic                     mosi;
  logic                     miso;
  logic [NUM_OF_SLAVES-1:0] ssel;

  modport master (
    input  start_i, num_txns_i, addr_byte_i, data_byte_i, miso,
    output rd_idx_o, rx_we_o, rx_idx_o, rx_data_o, busy_o, done_o, err_o,
           sclk, mosi, ssel
  );

  modport slave (
    output start_i, num_txns_i, addr_byte_i, data_byte_i, miso,
    input  rd_idx_o, rx_we_o, rx_idx_o, rx_data_o, busy_o, done_o, err_o,
           sclk, mosi, ssel
  );

endinterface

// File: rtl/spi_txn_sequencer_clk_div.sv
// Loadable half-period down-counter; tick is high in the last cycle of
// every CLK_DIV-cycle period. load restarts a full period next cycle.
module spi_clk_div
  import spi_txn_sequencer_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic pclk_i,
  input  logic prst_i,
  input  logic load,
  output logic tick
);
  localparam int             CW     = cnt_width(CLK_DIV);
  localparam logic [CW-1:0]  RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      cnt_q <= '0;
    end else if (load || (cnt_q == '0)) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/spi_txn_sequencer.sv
// SPI mode-3 master walking the register-file transaction list: address
// byte then data byte per entry, data-phase miso byte returned for write-back.
module spi_txn_sequencer
  import spi_txn_sequencer_pkg::*;
#(
  parameter int NUM_OF_SLAVES = 3,
  parameter int WIDTH         = 8,
  parameter int MAX_TXNS      = 8,
  parameter int CLK_DIV       = DEF_CLK_DIV
) (
  input  logic                 pclk_i,
  input  logic                 prst_i,
  spi_txn_sequencer_if.master  bus
);
  localparam int IDXW = $clog2(MAX_TXNS);
  localparam int SRW  = 2 * WIDTH;
  localparam int BCW  = $clog2(SRW);
  localparam int SLVW = SLV_FIELD_W;

  state_t                   state_q, state_d;
  logic [IDXW-1:0]          idx_q, idx_d;
  logic [IDXW-1:0]          count_q, count_d;
  logic [SRW-1:0]           sr_q, sr_d;
  logic [WIDTH-1:0]         rx_sh_q, rx_sh_d;
  logic [BCW-1:0]           bit_q, bit_d;
  logic                     phase_q, phase_d;
  logic [SLVW-1:0]          slv_q, slv_d;
  logic                     err_q, err_d;
  logic                     rx_we_q, rx_we_d;
  logic [IDXW-1:0]          rx_idx_q, rx_idx_d;
  logic [WIDTH-1:0]         rx_data_q, rx_data_d;
  logic                     sclk_q, sclk_d;
  logic                     mosi_q, mosi_d;
  logic [NUM_OF_SLAVES-1:0] ssel_q, ssel_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     sel_active_d;
  logic [SLVW-1:0]          slv_addr;
  logic                     tick;

  assign slv_addr = bus.addr_byte_i[WIDTH-1 -: SLVW];

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .pclk_i (pclk_i),
    .prst_i (prst_i),
    .load   (state_q == ST_LOAD),
    .tick   (tick)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    count_d   = count_q;
    sr_d      = sr_q;
    rx_sh_d   = rx_sh_q;
    bit_d     = bit_q;
    phase_d   = phase_q;
    slv_d     = slv_q;
    err_d     = err_q;
    rx_we_d   = 1'b0;
    rx_idx_d  = rx_idx_q;
    rx_data_d = rx_data_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          count_d = bus.num_txns_i;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        sr_d    = {bus.addr_byte_i, bus.data_byte_i};
        slv_d   = slv_addr;
        rx_sh_d = '0;
        bit_d   = '0;
        phase_d = 1'b0;
        if (int'(slv_addr) >= NUM_OF_SLAVES) begin
          err_d   = 1'b1;
          state_d = ST_GAP;
        end else begin
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tick) state_d = ST_SHIFT;
      end
      // phase_q=0 is the sclk-low half; its end is the rising sclk edge.
      ST_SHIFT: begin
        if (tick) begin
          if (!phase_q) begin
            phase_d = 1'b1;
            if (bit_q >= BCW'(WIDTH)) rx_sh_d = {rx_sh_q[WIDTH-2:0], bus.miso};
          end else if (bit_q == BCW'(SRW - 1)) begin
            state_d = ST_HOLD;
          end else begin
            phase_d = 1'b0;
            bit_d   = bit_q + BCW'(1);
            sr_d    = {sr_q[SRW-2:0], 1'b1};
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          rx_we_d   = 1'b1;
          rx_idx_d  = idx_q;
          rx_data_d = rx_sh_q;
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (idx_q == count_q) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + IDXW'(1);
            state_d = ST_LOAD;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Pin and status values are derived from the next state so they leave flops.
    sel_active_d = (state_d == ST_SETUP) || (state_d == ST_SHIFT) || (state_d == ST_HOLD);
    sclk_d       = !((state_d == ST_SHIFT) && !phase_d);
    mosi_d       = sel_active_d ? sr_d[SRW-1] : 1'b1;
    for (int i = 0; i < NUM_OF_SLAVES; i++) begin
      ssel_d[i] = sel_active_d && (slv_d == SLVW'(i));
    end
    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge pclk_i or posedge prst_i) begin
    if (prst_i) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      count_q   <= '0;
      sr_q      <= '1;
      rx_sh_q   <= '0;
      bit_q     <= '0;
      phase_q   <= 1'b0;
      slv_q     <= '0;
      err_q     <= 1'b0;
      rx_we_q   <= 1'b0;
      rx_idx_q  <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b1;
      mosi_q    <= 1'b1;
      ssel_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      count_q   <= count_d;
      sr_q      <= sr_d;
      rx_sh_q   <= rx_sh_d;
      bit_q     <= bit_d;
      phase_q   <= phase_d;
      slv_q     <= slv_d;
      err_q     <= err_d;
      rx_we_q   <= rx_we_d;
      rx_idx_q  <= rx_idx_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      ssel_q    <= ssel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.rd_idx_o  = idx_q;
  assign bus.rx_we_o   = rx_we_q;
  assign bus.rx_idx_o  = rx_idx_q;
  assign bus.rx_data_o = rx_data_q;
  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;
  assign bus.err_o     = err_q;
  assign bus.sclk      = sclk_q;
  assign bus.mosi      = mosi_q;
  assign bus.ssel      = ssel_q;

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Scoreboard bench for spi_txn_sequencer: directed transaction lists, a mode-3
// slave model, and a monitor checking SPI frames and write-back strobes.
module tb_spi_txn_sequencer;
  localparam int NS = 3;
  localparam int W  = 8;
  localparam int MT = 8;
  localparam int CD = 4;

  typedef struct packed {
    logic [2:0]  ssel;
    logic [15:0] frame;
  } frm_t;

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] data;
  } rx_t;

  logic pclk = 1'b0;
  logic prst = 1'b1;

  spi_txn_sequencer_if #(.NUM_OF_SLAVES(NS), .WIDTH(W), .MAX_TXNS(MT)) bus ();

  spi_txn_sequencer #(
    .NUM_OF_SLAVES (NS),
    .WIDTH         (W),
    .MAX_TXNS      (MT),
    .CLK_DIV       (CD)
  ) dut (
    .pclk_i (pclk),
    .prst_i (prst),
    .bus    (bus)
  );

  always #5 pclk = ~pclk;

  logic [7:0] addr_mem [MT];
  logic [7:0] data_mem [MT];
  logic [7:0] resp_mem [MT];

  assign bus.addr_byte_i = addr_mem[bus.rd_idx_o];
  assign bus.data_byte_i = data_mem[bus.rd_idx_o];

  frm_t exp_frm [$];
  rx_t  exp_rx  [$];

  int checks = 0;
  int passed = 0;
  int rx_seen = 0;
  int done_seen = 0;
  int onehot_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Loads one register-file entry; a nonzero exp_ssel means a frame and a strobe are due.
  task automatic add_entry(input int i, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] r, input logic [2:0] exp_ssel);
    addr_mem[i] = a;
    data_mem[i] = d;
    resp_mem[i] = r;
    if (exp_ssel != 3'b000) begin
      exp_frm.push_back('{ssel: exp_ssel, frame: {a, d}});
      exp_rx.push_back('{idx: 3'(i), data: r});
    end
  endtask

  // Mode-3 slave: drives the response byte MSB-first on falling sclk in the data phase.
  logic [2:0] s_prev_ssel = '0;
  logic       s_prev_sclk = 1'b1;
  logic [7:0] s_sh = '1;
  int         s_cnt = 0;

  initial begin
    bus.miso = 1'b1;
    forever begin
      @(negedge pclk);
      if (bus.ssel != 3'b000 && s_prev_ssel == 3'b000) begin
        s_sh  = resp_mem[bus.rd_idx_o];
        s_cnt = 0;
      end
      if (bus.ssel != 3'b000 && !bus.sclk && s_prev_sclk) begin
        if (s_cnt >= 8) begin
          bus.miso = s_sh[7];
          s_sh     = {s_sh[6:0], 1'b1};
        end
        s_cnt++;
      end
      if (bus.ssel == 3'b000) bus.miso = 1'b1;
      s_prev_ssel = bus.ssel;
      s_prev_sclk = bus.sclk;
    end
  end

  // Monitor: pops the scoreboard on each strobe and at the end of each ssel frame.
  logic [2:0]  m_prev_ssel = '0;
  logic        m_prev_sclk = 1'b1;
  logic        m_active = 1'b0;
  logic [2:0]  m_cur = '0;
  logic [15:0] m_frm = '0;
  int          m_nbits = 0;
  int          m_dur = 0;

  initial begin
    frm_t ef;
    rx_t  er;
    forever begin
      @(negedge pclk);
      if (prst) begin
        m_active    = 1'b0;
        m_prev_ssel = '0;
        m_prev_sclk = 1'b1;
      end else begin
        if (bus.rx_we_o) begin
          rx_seen++;
          if (exp_rx.size() == 0) begin
            chk("rx_unexpected_strobe", int'(bus.rx_idx_o), -1);
          end else begin
            er = exp_rx.pop_front();
            chk("rx_idx", int'(bus.rx_idx_o), int'(er.idx));
            chk("rx_data", int'(bus.rx_data_o), int'(er.data));
          end
        end
        if (bus.done_o) done_seen++;
        if (!$onehot0(bus.ssel)) onehot_bad++;
        if (bus.ssel != 3'b000 && m_prev_ssel == 3'b000) begin
          m_active = 1'b1;
          m_cur    = bus.ssel;
          m_frm    = '0;
          m_nbits  = 0;
          m_dur    = 0;
        end
        if (m_active && bus.ssel != 3'b000) begin
          m_dur++;
          if (bus.ssel != m_cur) onehot_bad++;
          if (bus.sclk && !m_prev_sclk) begin
            m_frm = {m_frm[14:0], bus.mosi};
            m_nbits++;
          end
        end
        if (m_active && bus.ssel == 3'b000) begin
          m_active = 1'b0;
          if (exp_frm.size() == 0) begin
            chk("frame_unexpected", int'(m_cur), 0);
          end else begin
            ef = exp_frm.pop_front();
            chk("frame_ssel", int'(m_cur), int'(ef.ssel));
            chk("frame_mosi", int'(m_frm), int'(ef.frame));
            chk("frame_bits", m_nbits, 16);
            chk("frame_ssel_cycles", m_dur, 136);
          end
        end
        m_prev_ssel = bus.ssel;
        m_prev_sclk = bus.sclk;
      end
    end
  end

  task automatic start_pulse(input int num);
    @(negedge pclk);
    bus.num_txns_i = 3'(num);
    bus.start_i    = 1'b1;
    @(negedge pclk);
    bus.start_i    = 1'b0;
    bus.num_txns_i = 3'd7;
  endtask

  // Runs one list; extra_at > 0 pulses start_i that many cycles in.
  task automatic run_list(input int num, input int exp_lat, input int extra_at, input string tag);
    int lat;
    lat = 0;
    start_pulse(num);
    chk({tag, "_busy_after_start"}, int'(bus.busy_o), 1);
    chk({tag, "_err_cleared"}, int'(bus.err_o), 0);
    while (!bus.done_o && lat < 3000) begin
      @(negedge pclk);
      lat++;
      bus.start_i = (lat == extra_at);
    end
    bus.start_i = 1'b0;
    chk({tag, "_done_latency"}, lat, exp_lat);
    chk({tag, "_busy_at_done"}, int'(bus.busy_o), 0);
    @(negedge pclk);
    chk({tag, "_done_one_cycle"}, int'(bus.done_o), 0);
  endtask

  initial begin
    bus.start_i    = 1'b0;
    bus.num_txns_i = '0;
    for (int i = 0; i < MT; i++) begin
      addr_mem[i] = '0;
      data_mem[i] = '0;
      resp_mem[i] = '0;
    end
    prst = 1'b1;
    repeat (3) @(negedge pclk);
    prst = 1'b0;
    repeat (20) @(negedge pclk);
    chk("idle_sclk", int'(bus.sclk), 1);
    chk("idle_mosi", int'(bus.mosi), 1);
    chk("idle_ssel", int'(bus.ssel), 0);
    chk("idle_busy", int'(bus.busy_o), 0);
    chk("idle_err", int'(bus.err_o), 0);
    chk("idle_rd_idx", int'(bus.rd_idx_o), 0);
    chk("idle_rx_idx", int'(bus.rx_idx_o), 0);
    chk("idle_rx_data", int'(bus.rx_data_o), 0);
    chk("idle_no_strobes", rx_seen + done_seen, 0);

    add_entry(0, 8'h05, 8'hA5, 8'h3C, 3'b001);
    run_list(0, 141, 0, "single");
    chk("single_err", int'(bus.err_o), 0);

    add_entry(0, 8'h11, 8'h3A, 8'h81, 3'b001);
    add_entry(1, 8'h52, 8'hC5, 8'h42, 3'b010);
    add_entry(2, 8'h93, 8'h7E, 8'hFF, 3'b100);
    run_list(2, 423, 0, "three");

    add_entry(0, 8'h05, 8'h11, 8'h99, 3'b001);
    add_entry(1, 8'hC0, 8'h22, 8'h77, 3'b000);
    add_entry(2, 8'h4B, 8'h33, 8'h66, 3'b010);
    run_list(2, 287, 0, "skip");
    chk("skip_err_sticky", int'(bus.err_o), 1);

    add_entry(0, 8'h86, 8'h5A, 8'hC3, 3'b100);
    run_list(0, 141, 40, "restart_ignored");

    // Reset lands in SHIFT bit 5 (sclk low, ssel=001, mosi=0); checked before any edge.
    add_entry(0, 8'h02, 8'hF0, 8'h55, 3'b000);
    add_entry(1, 8'h7F, 8'h0F, 8'hAA, 3'b000);
    start_pulse(1);
    repeat (46) @(negedge pclk);
    chk("pre_reset_sclk_low", int'(bus.sclk), 0);
    #1 prst = 1'b1;
    #1;
    chk("async_rst_sclk", int'(bus.sclk), 1);
    chk("async_rst_mosi", int'(bus.mosi), 1);
    chk("async_rst_ssel", int'(bus.ssel), 0);
    chk("async_rst_busy", int'(bus.busy_o), 0);
    repeat (3) @(negedge pclk);
    prst = 1'b0;
    chk("rst_rd_idx", int'(bus.rd_idx_o), 0);
    chk("rst_no_strobe", rx_seen, 7);
    add_entry(0, 8'h02, 8'hF0, 8'h55, 3'b001);
    add_entry(1, 8'h7F, 8'h0F, 8'hAA, 3'b010);
    run_list(1, 282, 0, "after_reset");

    repeat (5) @(negedge pclk);
    chk("frames_outstanding", exp_frm.size(), 0);
    chk("rx_outstanding", exp_rx.size(), 0);
    chk("rx_strobe_total", rx_seen, 9);
    chk("done_pulse_total", done_seen, 5);
    chk("ssel_onehot_stable", onehot_bad, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
